// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG row-IDCT input feeder: coefficient width,
// read-side state encodings and the zigzag-to-natural position table.
package jpeg_pkg;

  localparam int COEF_W = 16;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_BEAT0 = 2'd1,
    RD_BEAT1 = 2'd2,
    RD_GAP   = 2'd3
  } rd_state_e;

  // Entry k holds the natural (row*8+col) position of zigzag position k.
  localparam logic [5:0] ZIGZAG_TO_NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/jpeg_zigzag_rom.sv
// Zigzag-to-natural coefficient position lookup. When remapping is disabled
// the incoming position is already natural and passes straight through.
module jpeg_zigzag_rom
  import jpeg_pkg::*;
#(
  parameter int ZIGZAG_EN = 1
) (
  input  logic [5:0] zz_idx_i,
  output logic [5:0] nat_idx_o
);

  generate
    if (ZIGZAG_EN != 0) begin : g_remap
      assign nat_idx_o = ZIGZAG_TO_NAT[zz_idx_i];
    end else begin : g_bypass
      assign nat_idx_o = zz_idx_i;
    end
  endgenerate

endmodule

// File: rtl/jpeg_idct_row_feed.sv
// Row-IDCT input producer. Sparse coefficients are collected into one of two
// 64-entry banks; a full bank is replayed row by row as two 4-coefficient
// beats, with a fixed idle gap after each row to match the IDCT's busy time.
// A per-bank presence mask makes omitted coefficients read as zero, so the
// banks themselves are never cleared.
module jpeg_idct_row_feed
  import jpeg_pkg::*;
#(
  parameter int ZIGZAG_EN = 1,
  parameter int ROW_GAP   = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inport_valid_i,
  input  logic [COEF_W-1:0] inport_data_i,
  input  logic [5:0]        inport_idx_i,
  input  logic              inport_eob_i,
  output logic              inport_accept_o,
  output logic              outport_valid_o,
  output logic [COEF_W-1:0] outport_data0_o,
  output logic [COEF_W-1:0] outport_data1_o,
  output logic [COEF_W-1:0] outport_data2_o,
  output logic [COEF_W-1:0] outport_data3_o,
  output logic [2:0]        outport_idx_o
);

  // The gap counter loads ROW_GAP-1 so the GAP state lasts exactly ROW_GAP
  // cycles; with ROW_GAP = 0 the GAP state is skipped entirely.
  localparam int            GAP_W    = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (ROW_GAP > 0) ? GAP_W'(ROW_GAP - 1) : '0;
  localparam bit            GAP_EN   = (ROW_GAP > 0);

  // Storage and per-bank flags
  logic [COEF_W-1:0]         mem_q [2][64];
  logic [1:0][63:0]          mask_q;
  logic [1:0]                full_q;
  logic                      wr_bank_q;
  logic                      rd_bank_q;

  // Read FSM state and registered outputs
  rd_state_e                 state_q;
  logic [2:0]                row_q;
  logic [GAP_W-1:0]          gap_cnt_q;
  logic                      out_valid_q;
  logic [3:0][COEF_W-1:0]    out_data_q;
  logic [2:0]                out_idx_q;

  // Combinational helpers
  logic [5:0]                wr_pos_s;
  logic                      accept_s;
  logic                      wr_fire_s;
  logic [2:0]                row_inc_d;
  logic [2:0]                rd_row_s;
  logic                      rd_half_s;
  logic [3:0][COEF_W-1:0]    beat_s;
  logic                      row_end_s;
  logic                      release_s;

  jpeg_zigzag_rom #(
    .ZIGZAG_EN (ZIGZAG_EN)
  ) u_zigzag_rom (
    .zz_idx_i  (inport_idx_i),
    .nat_idx_o (wr_pos_s)
  );

  // Accept depends only on registered flags; a bank freed this cycle is
  // visible to the writer from the next cycle on.
  assign accept_s  = ~full_q[wr_bank_q];
  assign wr_fire_s = inport_valid_i & accept_s;
  assign row_inc_d = row_q + 3'd1;

  // A row ends after the last gap cycle, or straight after beat 1 with no gap.
  assign row_end_s = ((state_q == RD_GAP) && (gap_cnt_q == '0)) ||
                     ((state_q == RD_BEAT1) && !GAP_EN);
  assign release_s = row_end_s && (row_q == 3'd7);

  // Coefficient write port; contents are qualified by the mask, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire_s) begin
      mem_q[wr_bank_q][wr_pos_s] <= inport_data_i;
    end
  end

  // Presence masks, full flags and write-bank pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q    <= '0;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
    end else begin
      if (wr_fire_s) begin
        mask_q[wr_bank_q][wr_pos_s] <= 1'b1;
        if (inport_eob_i) begin
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= ~wr_bank_q;
        end
      end
      // Never the write bank: a full bank is not accepting writes.
      if (release_s) begin
        full_q[rd_bank_q] <= 1'b0;
        mask_q[rd_bank_q] <= 64'd0;
      end
    end
  end

  // Select which row/half the next registered beat will carry.
  always_comb begin
    rd_row_s  = 3'd0;
    rd_half_s = 1'b0;
    case (state_q)
      RD_IDLE: begin
        rd_row_s  = 3'd0;
        rd_half_s = 1'b0;
      end
      RD_BEAT0: begin
        rd_row_s  = row_q;
        rd_half_s = 1'b1;
      end
      RD_BEAT1, RD_GAP: begin
        rd_row_s  = row_inc_d;
        rd_half_s = 1'b0;
      end
      default: begin
        rd_row_s  = 3'd0;
        rd_half_s = 1'b0;
      end
    endcase
  end

  // Gather four coefficients of the selected half-row, zero where unwritten.
  always_comb begin
    beat_s = '0;
    for (int c = 0; c < 4; c++) begin
      if (mask_q[rd_bank_q][{rd_row_s, rd_half_s, 2'(c)}]) begin
        beat_s[c] = mem_q[rd_bank_q][{rd_row_s, rd_half_s, 2'(c)}];
      end else begin
        beat_s[c] = '0;
      end
    end
  end

  // Read FSM: state names the beat currently on the registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RD_IDLE;
      row_q       <= 3'd0;
      gap_cnt_q   <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 3'd0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q     <= RD_BEAT0;
            row_q       <= 3'd0;
            out_valid_q <= 1'b1;
            out_data_q  <= beat_s;
            out_idx_q   <= 3'd0;
          end else begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 3'd0;
          end
        end
        RD_BEAT0: begin
          state_q     <= RD_BEAT1;
          out_valid_q <= 1'b1;
          out_data_q  <= beat_s;
          out_idx_q   <= row_q;
        end
        RD_BEAT1, RD_GAP: begin
          if (row_end_s) begin
            if (row_q == 3'd7) begin
              state_q     <= RD_IDLE;
              row_q       <= 3'd0;
              rd_bank_q   <= ~rd_bank_q;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_idx_q   <= 3'd0;
            end else begin
              state_q     <= RD_BEAT0;
              row_q       <= row_inc_d;
              out_valid_q <= 1'b1;
              out_data_q  <= beat_s;
              out_idx_q   <= row_inc_d;
            end
          end else if (state_q == RD_BEAT1) begin
            state_q     <= RD_GAP;
            gap_cnt_q   <= GAP_LOAD;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 3'd0;
          end else begin
            gap_cnt_q   <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: begin
          state_q     <= RD_IDLE;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_idx_q   <= 3'd0;
        end
      endcase
    end
  end

  assign inport_accept_o = accept_s;
  assign outport_valid_o = out_valid_q;
  assign outport_data0_o = out_data_q[0];
  assign outport_data1_o = out_data_q[1];
  assign outport_data2_o = out_data_q[2];
  assign outport_data3_o = out_data_q[3];
  assign outport_idx_o   = out_idx_q;

endmodule

// File: tb/tb_jpeg_idct_row_feed.sv
// Scoreboard bench for jpeg_idct_row_feed: one instance with zigzag remap and
// one with natural ordering, driven by the same coefficient stream.
module tb_jpeg_idct_row_feed;

  localparam int ROW_GAP = 9;
  localparam int BLOCK_T = 8 * (2 + ROW_GAP);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic [5:0]  in_idx = 6'd0;
  logic        in_eob = 1'b0;

  logic        zz_accept, zz_valid;
  logic [15:0] zz_d0, zz_d1, zz_d2, zz_d3;
  logic [2:0]  zz_idx;
  logic        nat_accept, nat_valid;
  logic [15:0] nat_d0, nat_d1, nat_d2, nat_d3;
  logic [2:0]  nat_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int eob_cyc = 0;
  int half_zz = 0, half_nat = 0, last_zz = 0, last_nat = 0, start_nat = 0;
  bit seen_r3 = 1'b0;

  logic [5:0]  zz_tab  [64];
  logic [15:0] blk_zz  [64];
  logic [15:0] blk_nat [64];
  logic [67:0] exp_zz  [$];
  logic [67:0] exp_nat [$];
  logic [67:0] mon_o, mon_e;

  jpeg_idct_row_feed #(.ZIGZAG_EN(1), .ROW_GAP(ROW_GAP)) u_dut_zz (
    .clk_i(clk), .rst_i(rst), .inport_valid_i(in_valid), .inport_data_i(in_data),
    .inport_idx_i(in_idx), .inport_eob_i(in_eob), .inport_accept_o(zz_accept),
    .outport_valid_o(zz_valid), .outport_data0_o(zz_d0), .outport_data1_o(zz_d1),
    .outport_data2_o(zz_d2), .outport_data3_o(zz_d3), .outport_idx_o(zz_idx));

  jpeg_idct_row_feed #(.ZIGZAG_EN(0), .ROW_GAP(ROW_GAP)) u_dut_nat (
    .clk_i(clk), .rst_i(rst), .inport_valid_i(in_valid), .inport_data_i(in_data),
    .inport_idx_i(in_idx), .inport_eob_i(in_eob), .inport_accept_o(nat_accept),
    .outport_valid_o(nat_valid), .outport_data0_o(nat_d0), .outport_data1_o(nat_d1),
    .outport_data2_o(nat_d2), .outport_data3_o(nat_d3), .outport_idx_o(nat_idx));

  always #5 clk = ~clk;

  // Cycle counter, read only at negative edges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_blk(input bit zz);
    logic [67:0] e;
    for (int r = 0; r < 8; r++) begin
      for (int h = 0; h < 2; h++) begin
        e = '0;
        e[66:64] = 3'(r);
        for (int c = 0; c < 4; c++) begin
          e[63 - 16*c -: 16] = zz ? blk_zz[r*8 + h*4 + c] : blk_nat[r*8 + h*4 + c];
        end
        if (zz) exp_zz.push_back(e);
        else    exp_nat.push_back(e);
      end
    end
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) begin
      blk_zz[i]  = 16'd0;
      blk_nat[i] = 16'd0;
    end
  endtask

  task automatic model_xfer(input logic [5:0] idx, input logic [15:0] data, input bit eob);
    blk_zz[zz_tab[idx]] = data;
    blk_nat[idx]        = data;
    if (eob) begin
      push_blk(1'b1);
      push_blk(1'b0);
      clear_blk();
    end
  endtask

  task automatic send(input logic [5:0] idx, input logic [15:0] data, input bit eob);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_idx = idx; in_data = data; in_eob = eob;
    while (!(zz_accept && nat_accept) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check_eq("accept_wait", 68'(w < 500), 68'd1);
    if (w < 500) begin
      model_xfer(idx, data, eob);
      if (eob) eob_cyc = cyc;
      @(posedge clk);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_eob   = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_zz.size() != 0 || exp_nat.size() != 0) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    repeat (ROW_GAP + 4) @(negedge clk);
    check_eq("drain_zz", 68'(exp_zz.size()), 68'd0);
    check_eq("drain_nat", 68'(exp_nat.size()), 68'd0);
  endtask

  // Scoreboard for the zigzag instance: data, row index, beat pairing, gap.
  always @(negedge clk) begin
    if (zz_valid) begin
      mon_o = {1'b0, zz_idx, zz_d0, zz_d1, zz_d2, zz_d3};
      if (exp_zz.size() == 0) begin
        check_eq("zz_extra_beat", 68'(exp_zz.size()), 68'd1);
      end else begin
        mon_e = exp_zz.pop_front();
        check_eq("zz_beat", mon_o, mon_e);
        if (half_zz == 0) begin
          if (mon_e[66:64] != 3'd0) check_eq("zz_row_gap", 68'(cyc - last_zz), 68'(ROW_GAP + 1));
          half_zz = 1;
        end else begin
          check_eq("zz_pair", 68'(cyc - last_zz), 68'd1);
          half_zz = 0;
        end
        last_zz = cyc;
      end
    end
  end

  // Scoreboard for the natural-order instance, also noting block starts.
  always @(negedge clk) begin
    if (nat_valid) begin
      if (exp_nat.size() == 0) begin
        check_eq("nat_extra_beat", 68'(exp_nat.size()), 68'd1);
      end else begin
        logic [67:0] e;
        e = exp_nat.pop_front();
        check_eq("nat_beat", {1'b0, nat_idx, nat_d0, nat_d1, nat_d2, nat_d3}, e);
        if (half_nat == 0) begin
          if (e[66:64] != 3'd0) check_eq("nat_row_gap", 68'(cyc - last_nat), 68'(ROW_GAP + 1));
          else start_nat = cyc;
          half_nat = 1;
        end else begin
          check_eq("nat_pair", 68'(cyc - last_nat), 68'd1);
          if (e[66:64] == 3'd3) seen_r3 = 1'b1;
          half_nat = 0;
        end
        last_nat = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, w, s0;
    // Zigzag order built by walking the anti-diagonals.
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz_tab[k] = 6'(r*8 + (s - r)); k++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
          zz_tab[k] = 6'(r*8 + (s - r)); k++;
        end
      end
    end
    clear_blk();

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_zz_out", {zz_valid, zz_idx, zz_d0, zz_d1, zz_d2, zz_d3}, 68'd0);
    check_eq("rst_nat_out", {nat_valid, nat_idx, nat_d0, nat_d1, nat_d2, nat_d3}, 68'd0);
    check_eq("rst_accept", {66'd0, zz_accept, nat_accept}, 68'd3);
    rst = 1'b0;

    // DC-only block and EOB-to-first-beat latency
    send(6'd0, 16'h0100, 1'b1);
    idle_in();
    w = 0;
    while (!nat_valid && w < 20) begin @(negedge clk); w++; end
    check_eq("latency", 68'(cyc - eob_cyc), 68'd2);
    drain();

    // Sparse zigzag-style block
    send(6'd2, 16'd5, 1'b0);
    send(6'd3, 16'd7, 1'b0);
    send(6'd63, 16'hFFFF, 1'b1);
    idle_in();
    drain();

    // Duplicate position: last write wins
    send(6'd10, 16'd3, 1'b0);
    send(6'd10, 16'd9, 1'b1);
    idle_in();
    drain();

    // Back-to-back: full block, then sparse block, then a held third block
    for (int i = 0; i < 64; i++) send(6'(i), 16'(i), (i == 63));
    send(6'd9, 16'h0A0A, 1'b0);
    send(6'd20, 16'h1234, 1'b1);
    idle_in();
    check_eq("accept_held", {66'd0, zz_accept, nat_accept}, 68'd0);
    s0 = start_nat;
    w = 0;
    while (!nat_accept && w < 400) begin @(negedge clk); w++; end
    check_eq("accept_rise", 68'(cyc - s0), 68'(BLOCK_T));
    send(6'd5, 16'h4321, 1'b0);
    send(6'd40, 16'h7FFF, 1'b1);
    idle_in();
    drain();

    // Reset during the row-3 gap with a partial block pending
    seen_r3 = 1'b0;
    send(6'd0, 16'h0200, 1'b0);
    send(6'd27, 16'h0BEE, 1'b1);
    send(6'd1, 16'h5555, 1'b0);
    send(6'd9, 16'h6666, 1'b0);
    idle_in();
    w = 0;
    while (!seen_r3 && w < 400) begin @(negedge clk); w++; end
    check_eq("row3_seen", 68'(seen_r3), 68'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_zz.delete();
    exp_nat.delete();
    clear_blk();
    half_zz = 0;
    half_nat = 0;
    @(negedge clk);
    check_eq("mid_rst_out", {zz_valid, zz_idx, zz_d0, zz_d1, zz_d2, zz_d3,
                             nat_valid, nat_idx} , 68'd0);
    check_eq("mid_rst_nat", {nat_d0, nat_d1, nat_d2, nat_d3}, 68'd0);
    check_eq("mid_rst_accept", {66'd0, zz_accept, nat_accept}, 68'd3);
    rst = 1'b0;
    send(6'd3, 16'h0042, 1'b1);
    idle_in();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jpeg_idct_row_feed.md
Name: jpeg_idct_row_feed

Overview:
- Producer for the row-IDCT input port.
- Accepts dequantised coefficients one per cycle, in zigzag or natural order, sparse (omitted positions are zero), terminated by an end-of-block flag.
- Buffers each 8x8 block in a ping-pong coefficient store.
- Replays the block row by row as two beats of four coefficients with a 3-bit row index, paced to the IDCT's fixed per-row busy time.

Parameters:
ZIGZAG_EN, 1, 1: inport_idx_i is a zigzag position remapped to natural order; 0: inport_idx_i is already natural (row*8+col).
ROW_GAP, 9, idle cycles inserted after each row's second beat before the next first beat (IDCT accept-to-ready turnaround).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
inport_valid_i  in  1  coefficient valid
inport_data_i  in  16  signed coefficient
inport_idx_i  in  6  coefficient position (zigzag or natural per ZIGZAG_EN)
inport_eob_i  in  1  last coefficient of block (qualified by valid)
inport_accept_o  out  1  write side can take a coefficient this cycle
outport_valid_o  out  1  beat valid
outport_data0_o  out  16  column 0 (beat 0) / column 4 (beat 1)
outport_data1_o  out  16  column 1 / 5
outport_data2_o  out  16  column 2 / 6
outport_data3_o  out  16  column 3 / 7
outport_idx_o  out  3  row index of beat

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - all outputs 0, except inport_accept_o = 1 in the first cycle after reset.
  - both banks empty; both presence masks cleared; write bank = 0; read FSM in IDLE.
- Storage:
  - 2 banks x 64 x 16-bit entries, each with a 64-bit presence mask.
  - Read data for an entry whose mask bit is clear is forced to 0. Banks never need a bulk clear.
- Write side:
  - Transfer occurs when inport_valid_i && inport_accept_o.
  - Position = ZIGZAG_EN ? zigzag_to_natural(inport_idx_i) : inport_idx_i.
  - Transfer writes the entry and sets its mask bit. A duplicate position in a block: last write wins.
  - On a transfer with inport_eob_i = 1, the current bank is marked full and the write bank toggles.
  - An EOB-only block (a single transfer) yields an all-zero block apart from that entry.
  - inport_accept_o = !full[write bank]; combinational from registered flags.
- Read FSM:
  - IDLE: if full[rd_bank] -> BEAT0 with row = 0.
  - BEAT0: drive valid, data = columns 0-3 of row, idx = row -> BEAT1.
  - BEAT1: drive valid, data = columns 4-7 of row, idx = row -> GAP with counter = ROW_GAP.
  - GAP: valid = 0. On counter reaching 0:
    - if row < 7: row + 1, go to BEAT0;
    - else: clear full[rd_bank] and mask[rd_bank], toggle rd_bank, go to IDLE.
  - Outputs are registered. outport_valid_o is high exactly in the BEAT0 and BEAT1 cycles; both beats of a row are back-to-back with the same idx.
- Latency: with read FSM idle, EOB accepted in cycle t -> first beat valid in cycle t+2.
- Per-block read time is 8*(2+ROW_GAP) + 1 cycles (IDLE/launch overhead included).
- Simultaneous events:
  - The read side freeing a bank in the same cycle the write side needs it: accept rises the next cycle (no combinational bypass).
  - Writes to the write bank during readout of the other bank are unaffected.
  - Read side and write side never address the same bank while it is full.
- inport_valid_i low: no state change on the write side. There is no output backpressure (the consumer must honour ROW_GAP).
- Reset mid-operation: aborts any replay; the partially filled block is discarded; the next beat requires a complete new block.

Decomposition:
- Shared package jpeg_pkg:
  - ZIGZAG_TO_NAT 64-entry 6-bit constant table;
  - read FSM state encodings;
  - COEF_W = 16.
- Sub-module jpeg_zigzag_rom: combinational 6-bit -> 6-bit lookup, bypassed when ZIGZAG_EN = 0.
- Bank storage and FSM stay in this module.

Test Plan:
- DC block: single transfer idx 0, data 0x0100, eob.
  - Row 0 beat 0 = {0x0100, 0, 0, 0}; all other beats 0.
  - Beat idx 0,0,1,1,...,7,7.
  - Exactly ROW_GAP invalid cycles between rows.
- Zigzag remap, ZIGZAG_EN = 1: idx 2 = 5 (natural 8), idx 3 = 7 (natural 16), idx 63 = -1 with eob.
  - Row 1 beat 0 col 0 = 5; row 2 col 0 = 7; row 7 beat 1 col 3 = 0xFFFF.
- Full 64-coefficient natural block, ZIGZAG_EN = 0, data = idx: row r beat 0 = {8r, 8r+1, 8r+2, 8r+3}; beat 1 = {8r+4..8r+7}.
- Back-to-back blocks:
  - Third block is held: inport_accept_o falls after two EOBs.
  - Rises the cycle after the first block's row-7 GAP ends.
  - No coefficients lost; second block's stale mask bits read as 0.
- Duplicate position 10 written 3 then 9 in one block: output 9 at row 1 col 2.
- rst_i asserted during row 3 GAP:
  - Outputs 0 next cycle; accept = 1.
  - A new block afterwards replays from row 0 with no residue from the aborted block.
